// File: rtl/button_press_counter.sv
// Push-button press counter: synchronise BTN_C, debounce it, detect the rising
// edge and count accepted presses on a 6-bit wrap-around counter shown on LED.
module button_press_counter #(
  parameter int DEBOUNCE_CYCLES = 1,
  parameter bit LED_ACTIVE_LOW  = 1'b0
) (
  input  logic       CLK,
  input  logic       BTN_RST,
  input  logic       BTN_C,
  output logic [5:0] LED
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]       LED_RST = LED_ACTIVE_LOW ? 6'h3F : 6'h00;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic             r_db_d;
  logic [CNT_W-1:0] r_db_cnt;
  logic [5:0]       r_count;
  logic [5:0]       r_led;
  logic             w_press;
  logic [5:0]       w_count_nxt;

  function automatic logic [5:0] led_drive(input logic [5:0] cnt);
    return LED_ACTIVE_LOW ? ~cnt : cnt;
  endfunction

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge CLK or posedge BTN_RST) begin
    if (BTN_RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= BTN_C;
      r_sync2 <= r_sync1;
    end
  end

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge CLK or posedge BTN_RST) begin
    if (BTN_RST) begin
      r_db     <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_sync2 == r_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_db     <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_press     = r_db & ~r_db_d;
  assign w_count_nxt = r_count + 6'd1;

  // Edge detect and press counter; LED is a register so the pins never glitch.
  always_ff @(posedge CLK or posedge BTN_RST) begin
    if (BTN_RST) begin
      r_db_d  <= 1'b0;
      r_count <= 6'd0;
      r_led   <= LED_RST;
    end else begin
      r_db_d <= r_db;
      if (w_press) begin
        r_count <= w_count_nxt;
        r_led   <= led_drive(w_count_nxt);
      end
    end
  end

  assign LED = r_led;

endmodule

// File: tb/tb_button_press_counter.sv
// Bench for button_press_counter: two instances (DEBOUNCE_CYCLES=1 active-high,
// DEBOUNCE_CYCLES=4 active-low) against a sample-history reference model.
module tb_button_press_counter;

  logic       CLK;
  logic       BTN_RST;
  logic       btn1;
  logic       btn4;
  logic [5:0] led1;
  logic [5:0] led4;

  int n_pass;
  int n_total;

  button_press_counter #(.DEBOUNCE_CYCLES(1), .LED_ACTIVE_LOW(1'b0)) dut1 (
    .CLK(CLK), .BTN_RST(BTN_RST), .BTN_C(btn1), .LED(led1)
  );

  button_press_counter #(.DEBOUNCE_CYCLES(4), .LED_ACTIVE_LOW(1'b1)) dut4 (
    .CLK(CLK), .BTN_RST(BTN_RST), .BTN_C(btn4), .LED(led4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: the debounced level flips once the last D button samples
  // seen through the two-flop lag all disagree with it; a count is taken on the
  // edge after the debounced level rises.
  bit m_hist [2][8];
  bit m_db   [2];
  bit m_db_d [2];
  int m_cnt  [2];
  int m_d    [2];

  function automatic void model_reset();
    for (int id = 0; id < 2; id++) begin
      for (int i = 0; i < 8; i++) m_hist[id][i] = 1'b0;
      m_db[id]   = 1'b0;
      m_db_d[id] = 1'b0;
      m_cnt[id]  = 0;
    end
  endfunction

  function automatic void model_edge(input int id, input bit s);
    bit press;
    bit flip;
    press = m_db[id] && !m_db_d[id];
    for (int i = 7; i > 0; i--) m_hist[id][i] = m_hist[id][i-1];
    m_hist[id][0] = s;
    flip = 1'b1;
    for (int i = 2; i <= m_d[id] + 1; i++)
      if (m_hist[id][i] == m_db[id]) flip = 1'b0;
    m_db_d[id] = m_db[id];
    if (flip) m_db[id] = !m_db[id];
    if (press) m_cnt[id] = (m_cnt[id] + 1) % 64;
  endfunction

  function automatic logic [5:0] exp_led(input int id);
    logic [5:0] c;
    c = 6'(m_cnt[id]);
    return (id == 1) ? ~c : c;
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic step(input bit b1, input bit b4);
    btn1 = b1;
    btn4 = b4;
    @(posedge CLK);
    model_edge(0, b1);
    model_edge(1, b4);
    @(negedge CLK);
    check("model_led1", led1, exp_led(0));
    check("model_led4", led4, exp_led(1));
  endtask

  task automatic do_reset(input int hold);
    BTN_RST = 1'b1;
    model_reset();
    #1;
    check("rst_led1_async", led1, 6'h00);
    check("rst_led4_async", led4, 6'h3F);
    repeat (hold) @(posedge CLK);
    @(negedge CLK);
    BTN_RST = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_d[0]  = 1;
    m_d[1]  = 4;
    btn1    = 1'b0;
    btn4    = 1'b0;
    BTN_RST = 1'b0;
    model_reset();

    // Reset: LED must clear before any clock edge, then stay at 0.
    do_reset(2);
    repeat (10) step(0, 0);
    check("rst_hold_led1", led1, 6'h00);
    check("rst_hold_led4", led4, 6'h3F);

    // Single press, exact three-edge latency, then a second press.
    step(1, 0);
    step(0, 0);
    step(0, 0);
    check("press_lat_k2", led1, 6'd0);
    step(0, 0);
    check("press_lat_k3", led1, 6'd1);
    step(1, 0);
    step(0, 0);
    step(1, 0);
    repeat (4) step(0, 0);
    check("two_press", led1, 6'd3);

    // Held press counts once.
    do_reset(2);
    repeat (20) step(1, 1);
    repeat (6) step(0, 0);
    check("held_led1", led1, 6'd1);
    check("held_led4", led4, ~6'd1);

    // Wrap 63 -> 0 -> 1.
    do_reset(2);
    repeat (64) begin
      step(1, 0);
      step(0, 0);
    end
    repeat (3) step(0, 0);
    check("wrap_64", led1, 6'd0);
    step(1, 0);
    repeat (3) step(0, 0);
    check("wrap_65", led1, 6'd1);

    // Glitch filter on the DEBOUNCE_CYCLES=4 instance.
    do_reset(2);
    repeat (3) step(0, 1);
    repeat (10) step(0, 0);
    check("glitch_3", led4, 6'h3F);
    repeat (4) step(0, 1);
    step(0, 0);
    step(0, 0);
    check("db4_k5", led4, 6'h3F);
    step(0, 0);
    check("db4_k6", led4, 6'h3E);

    // Reset during activity.
    do_reset(2);
    step(1, 0);
    step(0, 0);
    step(1, 0);
    repeat (4) step(0, 0);
    check("act_pre_rst", led1, 6'd2);
    do_reset(1);
    repeat (2) step(0, 0);
    check("act_post_rst", led1, 6'd0);

    // Reset in the middle of a pending press discards it.
    step(0, 1);
    step(0, 1);
    step(0, 1);
    btn4 = 1'b0;
    do_reset(1);
    repeat (8) step(0, 0);
    check("mid_db_rst", led4, 6'h3F);

    // Randomised toggling, with occasional resets (buttons may be held across them).
    for (int n = 0; n < 600; n++) begin
      bit b1;
      bit b4;
      b1 = ($urandom_range(0, 2) == 0) ? !btn1 : btn1;
      b4 = ($urandom_range(0, 3) == 0) ? !btn4 : btn4;
      if ($urandom_range(0, 149) == 0) begin
        btn1 = b1;
        btn4 = b4;
        do_reset($urandom_range(1, 3));
      end else begin
        step(b1, b4);
      end
    end
    repeat (8) step(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
